random_arbiter: RTL and testbench

- Shares the single reverse-bit-order random counter between NUM_REQ game requesters, e.g. platform spacing and platform width generators.
- Drives the counter's roll enable: free-running while idle, frozen while a sample is taken.
- Grants requesters round-robin, then reduces the sampled value into the winner's range [0, bound) by iterative subtraction.
- Returns the result on a shared value bus with a one-cycle per-requester ack.

---
 rtl/random_arbiter.sv | 139 +++++++++++++
 tb/tb_random_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/random_arbiter.sv
// random_arbiter: round-robin sharing of one free-running random counter, reducing each sample into
// the winning requester's range. Define RANDOM_ARBITER_NO_REPEAT_EN to reroll repeated results.
module random_arbiter #(
  parameter int WIDTH   = 7,
  parameter int NUM_REQ = 2
) (
  input  logic                     clk_random_arbiter,
  input  logic                     rst_random_arbiter,
  input  logic [NUM_REQ-1:0]       i_req,
  input  logic [NUM_REQ*WIDTH-1:0] i_bound,
  input  logic [WIDTH-1:0]         i_random_binary,
  output logic                     o_roll,
  output logic [NUM_REQ-1:0]       o_ack,
  output logic [WIDTH-1:0]         o_value,
  output logic                     o_busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    IDLE,
    SAMPLE,
    REDUCE,
`ifdef RANDOM_ARBITER_NO_REPEAT_EN
    REROLL,
`endif
    DONE
  } state_t;

  state_t           state;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] winner;
  logic [PTR_W-1:0] pick;
  logic [PTR_W-1:0] scan_idx;
  logic             found;
  logic [WIDTH-1:0] bound_q;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] pick_bound;
  logic             is_final;

`ifdef RANDOM_ARBITER_NO_REPEAT_EN
  logic [WIDTH-1:0]   last_q [NUM_REQ];
  logic [NUM_REQ-1:0] valid_q;
  logic               repeat_hit;
`endif

  // Round-robin search starts just above the last winner and wraps.
  always_comb begin
    found    = 1'b0;
    pick     = '0;
    scan_idx = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      scan_idx = PTR_W'((int'(ptr) + off) % NUM_REQ);
      if (!found && i_req[scan_idx]) begin
        found = 1'b1;
        pick  = scan_idx;
      end
    end
  end

  assign pick_bound = i_bound[pick*WIDTH +: WIDTH];
  assign is_final   = (bound_q == '0) || (work < bound_q);

`ifdef RANDOM_ARBITER_NO_REPEAT_EN
  // A bound of 1 can only ever yield 0, so rerolling would never terminate.
  assign repeat_hit = valid_q[winner] && (work == last_q[winner]) && (bound_q != WIDTH'(1));
  assign o_roll     = (state == IDLE) || (state == REROLL);
`else
  assign o_roll     = (state == IDLE);
`endif

  assign o_busy = (state != IDLE);

  always_ff @(posedge clk_random_arbiter) begin
    if (!rst_random_arbiter) begin
      state   <= IDLE;
      o_ack   <= '0;
      o_value <= '0;
      ptr     <= PTR_W'(NUM_REQ - 1);
      winner  <= '0;
      bound_q <= '0;
      work    <= '0;
`ifdef RANDOM_ARBITER_NO_REPEAT_EN
      valid_q <= '0;
      for (int r = 0; r < NUM_REQ; r++) begin
        last_q[r] <= '0;
      end
`endif
    end else begin
      o_ack <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            winner  <= pick;
            bound_q <= pick_bound;
            state   <= SAMPLE;
          end
        end
        SAMPLE: begin
          work  <= i_random_binary;
          state <= REDUCE;
        end
        // Modulo by repeated subtraction; only subtracts when work >= bound.
        REDUCE: begin
          if (!is_final) begin
            work <= work - bound_q;
          end
`ifdef RANDOM_ARBITER_NO_REPEAT_EN
          else if (repeat_hit) begin
            state <= REROLL;
          end
`endif
          else begin
            state   <= DONE;
            o_value <= work;
            o_ack   <= NUM_REQ'(1) << winner;
            ptr     <= winner;
`ifdef RANDOM_ARBITER_NO_REPEAT_EN
            last_q[winner]  <= work;
            valid_q[winner] <= 1'b1;
`endif
          end
        end
`ifdef RANDOM_ARBITER_NO_REPEAT_EN
        REROLL: begin
          state <= SAMPLE;
        end
`endif
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_random_arbiter.sv
// tb_random_arbiter: transaction-level timestamp model checked every cycle, plus directed literal cases.
// Honours RANDOM_ARBITER_NO_REPEAT_EN when defined for the build.
module tb_random_arbiter;

  localparam int W = 7;
  localparam int N = 2;

`ifdef RANDOM_ARBITER_NO_REPEAT_EN
  localparam logic [W-1:0] NR_EXP_VAL = 7'd1;
  localparam int           NR_EXP_LAT = 8;
  localparam bit           NR_EN      = 1'b1;
`else
  localparam logic [W-1:0] NR_EXP_VAL = 7'd2;
  localparam int           NR_EXP_LAT = 3;
  localparam bit           NR_EN      = 1'b0;
`endif

  logic           clk_random_arbiter = 1'b0;
  logic           rst_random_arbiter;
  logic [N-1:0]   i_req;
  logic [N*W-1:0] i_bound;
  logic [W-1:0]   i_random_binary;
  logic           o_roll;
  logic [N-1:0]   o_ack;
  logic [W-1:0]   o_value;
  logic           o_busy;

  int tests_run    = 0;
  int tests_failed = 0;

  random_arbiter #(.WIDTH(W), .NUM_REQ(N)) dut (
    .clk_random_arbiter(clk_random_arbiter),
    .rst_random_arbiter(rst_random_arbiter),
    .i_req(i_req),
    .i_bound(i_bound),
    .i_random_binary(i_random_binary),
    .o_roll(o_roll),
    .o_ack(o_ack),
    .o_value(o_value),
    .o_busy(o_busy)
  );

  always #5 clk_random_arbiter = ~clk_random_arbiter;

  initial begin
    #800000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: each transaction is a set of edge timestamps derived from sample/bound arithmetic.
  int           m_cyc = 0;
  bit           m_ready = 1'b0;
  bit           m_idle;
  int           m_ptr, m_win, m_bound, m_res;
  int           sample_at, ack_at, idle_at, reroll_at;
  int           last_v [N];
  bit           valid_v [N];
  logic [N-1:0] e_ack;
  logic [W-1:0] e_value;
  bit           e_busy, e_roll;

  always @(posedge clk_random_arbiter) begin : model
    int s;
    int k;
    m_cyc++;
    e_ack = '0;
    if (!rst_random_arbiter) begin
      m_ready   = 1'b1;
      m_idle    = 1'b1;
      m_ptr     = N - 1;
      e_value   = '0;
      sample_at = -1;
      ack_at    = -1;
      idle_at   = -1;
      reroll_at = -1;
      for (int r = 0; r < N; r++) begin
        valid_v[r] = 1'b0;
        last_v[r]  = 0;
      end
    end else if (m_ready) begin
      if (m_idle) begin
        if (i_req != '0) begin
          for (int off = 1; off <= N; off++) begin
            if (((int'(i_req) >> ((m_ptr + off) % N)) & 1) == 1) begin
              m_win = (m_ptr + off) % N;
              break;
            end
          end
          m_bound   = int'(i_bound >> (m_win * W)) & ((1 << W) - 1);
          sample_at = m_cyc + 1;
          ack_at    = -1;
          m_idle    = 1'b0;
        end
      end else if (m_cyc == sample_at) begin
        s     = int'(i_random_binary);
        k     = (m_bound == 0) ? 0 : s / m_bound;
        m_res = (m_bound == 0) ? s : s % m_bound;
        if (NR_EN && valid_v[m_win] && m_res == last_v[m_win] && m_bound != 1) begin
          reroll_at = m_cyc + 1 + k;
          sample_at = m_cyc + k + 3;
        end else begin
          ack_at = m_cyc + 1 + k;
        end
      end else if (m_cyc == ack_at) begin
        e_ack[m_win]   = 1'b1;
        e_value        = W'(m_res);
        m_ptr          = m_win;
        last_v[m_win]  = m_res;
        valid_v[m_win] = 1'b1;
        idle_at        = m_cyc + 1;
      end else if (m_cyc == idle_at) begin
        m_idle = 1'b1;
      end
    end
    e_busy = !m_idle;
    e_roll = m_idle || (m_cyc == reroll_at);
  end

  // Compare every cycle once the model has seen a reset.
  always @(posedge clk_random_arbiter) begin
    #1;
    if (m_ready) begin
      checkOutput("cyc_ack",   32'(o_ack),   32'(e_ack));
      checkOutput("cyc_value", 32'(o_value), 32'(e_value));
      checkOutput("cyc_busy",  32'(o_busy),  32'(e_busy));
      checkOutput("cyc_roll",  32'(o_roll),  32'(e_roll));
    end
  end

  // One-cycle request pulse; s2 replaces the counter value after the first capture.
  task automatic applyStimulus(input logic [N-1:0] req, input logic [W-1:0] b0, input logic [W-1:0] b1,
                               input logic [W-1:0] s1, input logic [W-1:0] s2,
                               output int lat, output logic [N-1:0] ack, output logic [W-1:0] val,
                               output int roll_hi);
    lat     = -1;
    ack     = '0;
    val     = '0;
    roll_hi = 0;
    @(negedge clk_random_arbiter);
    i_req           = req;
    i_bound         = {b1, b0};
    i_random_binary = s1;
    @(posedge clk_random_arbiter);
    @(negedge clk_random_arbiter);
    i_req = '0;
    if (o_roll) roll_hi++;
    for (int n = 1; n <= 300; n++) begin
      @(posedge clk_random_arbiter);
      @(negedge clk_random_arbiter);
      if (n == 1) i_random_binary = s2;
      if (o_roll) roll_hi++;
      if (o_ack != '0) begin
        lat = n;
        ack = o_ack;
        val = o_value;
        break;
      end
    end
    @(negedge clk_random_arbiter);
  endtask

  function automatic logic [W-1:0] randBound();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel == 0) return '0;
    if (sel == 1) return W'(1);
    return W'($urandom_range(2, (1 << W) - 1));
  endfunction

  int           lat, roll_hi, nack, acks;
  logic [N-1:0] ack;
  logic [W-1:0] val;
  logic [N-1:0] rr_ack [4];
  logic [W-1:0] rr_val [4];

  initial begin
    rst_random_arbiter = 1'b0;
    i_req              = '0;
    i_bound            = '0;
    i_random_binary    = '0;
    repeat (3) @(negedge clk_random_arbiter);
    rst_random_arbiter = 1'b1;
    checkOutput("reset_ack",   32'(o_ack),   32'd0);
    checkOutput("reset_value", 32'(o_value), 32'd0);
    checkOutput("reset_busy",  32'(o_busy),  32'd0);
    checkOutput("reset_roll",  32'(o_roll),  32'd1);

    // bound 10, sample 37 -> 7 after three subtractions
    applyStimulus(2'b01, 7'd10, 7'd0, 7'd37, 7'd37, lat, ack, val, roll_hi);
    checkOutput("b10_value",   32'(val),     32'd7);
    checkOutput("b10_ack",     32'(ack),     32'd1);
    checkOutput("b10_latency", 32'(lat),     32'd5);
    checkOutput("b10_roll_hi", 32'(roll_hi), 32'd0);

    applyStimulus(2'b10, 7'd0, 7'd0, 7'd100, 7'd100, lat, ack, val, roll_hi);
    checkOutput("b0_value",   32'(val), 32'd100);
    checkOutput("b0_ack",     32'(ack), 32'd2);
    checkOutput("b0_latency", 32'(lat), 32'd2);

    applyStimulus(2'b01, 7'd1, 7'd0, 7'd127, 7'd127, lat, ack, val, roll_hi);
    checkOutput("b1_value",   32'(val), 32'd0);
    checkOutput("b1_latency", 32'(lat), 32'd129);

    // requester 1 pulsed once: one ack, no regrant
    applyStimulus(2'b10, 7'd0, 7'd9, 7'd50, 7'd50, lat, ack, val, roll_hi);
    checkOutput("pulse_ack",     32'(ack), 32'd2);
    checkOutput("pulse_value",   32'(val), 32'd5);
    checkOutput("pulse_latency", 32'(lat), 32'd7);
    acks = 0;
    repeat (100) begin
      @(negedge clk_random_arbiter);
      if (o_ack != '0) acks++;
    end
    checkOutput("pulse_no_regrant", 32'(acks), 32'd0);

    // reset held for three cycles in the middle of a long reduction
    @(negedge clk_random_arbiter);
    i_req           = 2'b01;
    i_bound         = {7'd0, 7'd1};
    i_random_binary = 7'd127;
    @(posedge clk_random_arbiter);
    @(negedge clk_random_arbiter);
    i_req = '0;
    repeat (10) @(negedge clk_random_arbiter);
    checkOutput("mid_busy", 32'(o_busy), 32'd1);
    rst_random_arbiter = 1'b0;
    repeat (3) @(negedge clk_random_arbiter);
    rst_random_arbiter = 1'b1;
    checkOutput("midrst_ack",   32'(o_ack),   32'd0);
    checkOutput("midrst_value", 32'(o_value), 32'd0);
    checkOutput("midrst_busy",  32'(o_busy),  32'd0);
    checkOutput("midrst_roll",  32'(o_roll),  32'd1);
    acks = 0;
    repeat (200) begin
      @(negedge clk_random_arbiter);
      if (o_ack != '0) acks++;
    end
    checkOutput("midrst_no_ack", 32'(acks), 32'd0);

    // repeat suppression: 6 -> 2, then 6 -> 2 again followed by 9 -> 1
    applyStimulus(2'b01, 7'd4, 7'd0, 7'd6, 7'd6, lat, ack, val, roll_hi);
    checkOutput("nr_first_value",   32'(val), 32'd2);
    checkOutput("nr_first_latency", 32'(lat), 32'd3);
    applyStimulus(2'b01, 7'd4, 7'd0, 7'd6, 7'd9, lat, ack, val, roll_hi);
    checkOutput("nr_second_value",   32'(val), 32'(NR_EXP_VAL));
    checkOutput("nr_second_latency", 32'(lat), 32'(NR_EXP_LAT));

    // both requesters held: grants alternate starting at 0 after reset
    @(negedge clk_random_arbiter);
    rst_random_arbiter = 1'b0;
    @(negedge clk_random_arbiter);
    rst_random_arbiter = 1'b1;
    i_req   = 2'b11;
    i_bound = {7'd3, 7'd5};
    nack    = 0;
    for (int n = 0; n < 2000 && nack < 4; n++) begin
      @(negedge clk_random_arbiter);
      i_random_binary = W'($urandom);
      if (o_ack != '0) begin
        rr_ack[nack] = o_ack;
        rr_val[nack] = o_value;
        nack++;
      end
    end
    i_req = '0;
    checkOutput("rr_count", 32'(nack), 32'd4);
    for (int i = 0; i < nack; i++) begin
      checkOutput("rr_ack_order", 32'(rr_ack[i]), (i % 2 == 0) ? 32'd1 : 32'd2);
      checkOutput("rr_value_lt_bound", 32'(rr_val[i] < ((i % 2 == 0) ? 7'd5 : 7'd3)), 32'd1);
    end
    repeat (3) @(negedge clk_random_arbiter);

    // randomized traffic, bounds and occasional resets; the model checks every cycle
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk_random_arbiter);
      i_random_binary    = W'($urandom);
      rst_random_arbiter = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 3) == 0) i_req = N'($urandom);
      if ($urandom_range(0, 7) == 0) i_bound = {randBound(), randBound()};
    end
    @(negedge clk_random_arbiter);
    rst_random_arbiter = 1'b1;
    i_req              = '0;
    repeat (2) @(negedge clk_random_arbiter);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
